// File: rtl/sd_spi_master.sv
// sd_spi_master: byte-wide SPI master (mode 0, MSB first) for the SD socket.
// Two IO ports selected by a0: a0=0 data (tx on write, last rx byte on read),
// a0=1 control (ssel_n, overrun clear, divider) / status
// {busy, overrun, 0, ssel_n, div[3:0]}.
// Ports:
//   clk, reset          bus clock, synchronous active-high reset
//   a0                  port select
//   wr_tick, rd_tick    one-cycle CPU IO write / read strobes
//   wdata, rdata        CPU write data / combinational read data
//   busy                transfer in progress
//   sd_miso, sd_mosi    card data out / card data in
//   sd_clk, sd_ssel_n   SPI clock / card select (active low)
module sd_spi_master #(
    parameter logic [3:0] DEFAULT_DIV = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a0,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    input  logic       sd_miso,
    output logic       sd_mosi,
    output logic       sd_clk,
    output logic       sd_ssel_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t     state;
    logic [3:0] div;
    logic [3:0] div_active;
    logic [3:0] hc;
    logic [2:0] bc;
    logic [7:0] tx;
    logic [7:0] sh;
    logic [7:0] rx;
    logic       overrun;

    always_comb begin
        rdata = rx;
        if (a0)
            rdata = {busy, overrun, 1'b0, sd_ssel_n, div};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sd_clk     <= 1'b0;
            sd_mosi    <= 1'b1;
            sd_ssel_n  <= 1'b1;
            busy       <= 1'b0;
            rx         <= 8'hFF;
            overrun    <= 1'b0;
            div        <= DEFAULT_DIV;
            div_active <= '0;
            hc         <= '0;
            bc         <= '0;
            tx         <= '0;
            sh         <= '0;
        end else begin
            // Register interface; a write in the same cycle as a read wins
            // and suppresses the status-read overrun clear.
            if (wr_tick) begin
                if (a0) begin
                    sd_ssel_n <= wdata[0];
                    div       <= wdata[7:4];
                    if (wdata[1])
                        overrun <= 1'b0;
                end else if (state != IDLE) begin
                    overrun <= 1'b1;
                end
            end else if (rd_tick && a0) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (wr_tick && !a0) begin
                        state      <= LOW;
                        busy       <= 1'b1;
                        sd_clk     <= 1'b0;
                        sd_mosi    <= wdata[7];
                        // tx holds the remaining bits left-aligned
                        tx         <= {wdata[6:0], 1'b0};
                        bc         <= 3'd7;
                        hc         <= '0;
                        div_active <= div;
                    end
                end
                LOW: begin
                    if (hc == div_active) begin
                        state  <= HIGH;
                        sd_clk <= 1'b1;
                        sh     <= {sh[6:0], sd_miso};
                        hc     <= '0;
                    end else begin
                        hc <= hc + 4'd1;
                    end
                end
                HIGH: begin
                    if (hc == div_active) begin
                        sd_clk <= 1'b0;
                        hc     <= '0;
                        if (bc != 3'd0) begin
                            state   <= LOW;
                            sd_mosi <= tx[7];
                            tx      <= {tx[6:0], 1'b0};
                            bc      <= bc - 3'd1;
                        end else begin
                            state   <= IDLE;
                            sd_mosi <= 1'b1;
                            busy    <= 1'b0;
                            rx      <= sh;
                        end
                    end else begin
                        hc <= hc + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master: directed self-checking bench for sd_spi_master.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sd_spi_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a0 = 1'b0;
    logic       wr_tick = 1'b0;
    logic       rd_tick = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy;
    logic       sd_miso = 1'b1;
    logic       sd_mosi;
    logic       sd_clk;
    logic       sd_ssel_n;

    int checks = 0;
    int failures = 0;

    sd_spi_master #(.DEFAULT_DIV(4'd15)) dut (
        .clk       (clk),
        .reset     (reset),
        .a0        (a0),
        .wr_tick   (wr_tick),
        .rd_tick   (rd_tick),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .sd_miso   (sd_miso),
        .sd_mosi   (sd_mosi),
        .sd_clk    (sd_clk),
        .sd_ssel_n (sd_ssel_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [7:0] d);
        a0 = sel;
        wdata = d;
        wr_tick = 1'b1;
        tick();
        wr_tick = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic sel, input logic [7:0] exp);
        a0 = sel;
        #1;
        check(tag, {24'h0, rdata}, {24'h0, exp});
    endtask

    // One data transfer. h = expected half-period in clk cycles.
    // miso_loop=1 loops sd_mosi back, otherwise pat is presented MSB first.
    // mid_at >= 0 issues a write (mid_a0, mid_d) during that cycle of the transfer.
    task automatic xfer(input string tag, input logic [7:0] d, input int h,
                        input logic miso_loop, input logic [7:0] pat,
                        input logic [7:0] exp_rx, input int mid_at,
                        input logic mid_a0, input logic [7:0] mid_d,
                        input logic stat_chk);
        int n;
        int rises;
        int rise_t[8];
        logic [7:0] bits;
        logic prev_clk;
        n = 0;
        rises = 0;
        bits = 8'h00;
        for (int i = 0; i < 8; i++) rise_t[i] = 0;
        wr(1'b0, d);
        check({tag, "_busy_start"}, {31'h0, busy}, 32'd1);
        prev_clk = sd_clk;
        while (busy && n < 2000) begin
            if (miso_loop)
                sd_miso = sd_mosi;
            else if (rises < 8)
                sd_miso = pat[7 - rises];
            if (n == mid_at) begin
                a0 = mid_a0;
                wdata = mid_d;
                wr_tick = 1'b1;
            end
            tick();
            wr_tick = 1'b0;
            n++;
            if (sd_clk && !prev_clk) begin
                if (rises < 8) begin
                    bits[7 - rises] = sd_mosi;
                    rise_t[rises] = n;
                end
                rises++;
            end
            prev_clk = sd_clk;
            if (stat_chk && n == 10) begin
                a0 = 1'b1;
                #1;
                check({tag, "_status_busy"}, {31'h0, rdata[7]}, 32'd1);
            end
        end
        check({tag, "_busy_cycles"}, n, 16 * h);
        check({tag, "_rises"}, rises, 32'd8);
        check({tag, "_mosi_bits"}, {24'h0, bits}, {24'h0, d});
        check({tag, "_first_rise"}, rise_t[0], h);
        check({tag, "_period"}, rise_t[1] - rise_t[0], 2 * h);
        check({tag, "_idle_clk"}, {31'h0, sd_clk}, 32'd0);
        check({tag, "_idle_mosi"}, {31'h0, sd_mosi}, 32'd1);
        rd_check({tag, "_rx"}, 1'b0, exp_rx);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        check("rst_sd_clk", {31'h0, sd_clk}, 32'd0);
        check("rst_mosi", {31'h0, sd_mosi}, 32'd1);
        check("rst_ssel_n", {31'h0, sd_ssel_n}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        rd_check("rst_status", 1'b1, 8'b0001_1111);
        rd_check("rst_data", 1'b0, 8'hFF);
        reset = 1'b0;
        tick();

        // div=0, select card, loopback A5
        wr(1'b1, 8'h00);
        check("ssel_low", {31'h0, sd_ssel_n}, 32'd0);
        rd_check("status_div0", 1'b1, 8'h00);
        xfer("a5", 8'hA5, 1, 1'b1, 8'h00, 8'hA5, -1, 1'b0, 8'h00, 1'b0);

        // div=3, pattern C3 on miso
        wr(1'b1, 8'h30);
        xfer("3c", 8'h3C, 4, 1'b0, 8'hC3, 8'hC3, -1, 1'b0, 8'h00, 1'b1);
        rd_check("status_after_3c", 1'b1, 8'h03);

        // Overrun, cleared by status read
        wr(1'b1, 8'h00);
        xfer("f0_ovr", 8'hF0, 1, 1'b1, 8'h00, 8'hF0, 3, 1'b0, 8'h11, 1'b0);
        rd_check("ovr_set1", 1'b1, 8'h40);
        a0 = 1'b1;
        rd_tick = 1'b1;
        tick();
        rd_tick = 1'b0;
        rd_check("ovr_clr_rd", 1'b1, 8'h00);

        // Overrun, cleared by control write bit1
        xfer("f0_ovr2", 8'hF0, 1, 1'b1, 8'h00, 8'hF0, 5, 1'b0, 8'h11, 1'b0);
        rd_check("ovr_set2", 1'b1, 8'h40);
        wr(1'b1, 8'h02);
        rd_check("ovr_clr_wr", 1'b1, 8'h00);

        // Divider change mid-transfer applies only to the next transfer
        xfer("div_mid", 8'h5A, 1, 1'b1, 8'h00, 8'h5A, 4, 1'b1, 8'h70, 1'b0);
        rd_check("status_div7", 1'b1, 8'h07);
        xfer("div7", 8'h96, 8, 1'b1, 8'h00, 8'h96, -1, 1'b0, 8'h00, 1'b0);

        // Reset mid-transfer
        wr(1'b1, 8'h00);
        wr(1'b0, 8'h55);
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", {31'h0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_clk", {31'h0, sd_clk}, 32'd0);
        check("mid_rst_mosi", {31'h0, sd_mosi}, 32'd1);
        check("mid_rst_ssel", {31'h0, sd_ssel_n}, 32'd1);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        rd_check("mid_rst_status", 1'b1, 8'h1F);
        rd_check("mid_rst_data", 1'b0, 8'hFF);
        reset = 1'b0;
        tick();
        wr(1'b1, 8'h00);
        xfer("81", 8'h81, 1, 1'b1, 8'h00, 8'h81, -1, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
